// File: rtl/phy_rst_seq_if.sv
// Management/port-control bundle for the PHY/MAC reset sequencer.
// The sequencer takes the slave side; the management agent drives the master side.
interface phy_rst_seq_if;
    logic soft_rst_req;
    logic soft_rst_ack;
    logic phy_rstn;
    logic mac_rstn;
    logic ready;

    modport master (
        output soft_rst_req,
        input  soft_rst_ack,
        input  phy_rstn,
        input  mac_rstn,
        input  ready
    );

    modport slave (
        input  soft_rst_req,
        output soft_rst_ack,
        output phy_rstn,
        output mac_rstn,
        output ready
    );
endinterface

// File: rtl/phy_rst_seq.sv
// PHY/MAC reset sequencer: holds the PHY in reset, waits for it to settle,
// releases the MAC, then reports ready. Management can re-run the sequence
// from RUN with a level request, acknowledged by a single-cycle pulse.
module phy_rst_seq #(
    parameter int RST_CYC  = 16,
    parameter int WAIT_CYC = 32,
    parameter int CNT_W    = 16
) (
    input  logic          sys_clk,
    input  logic          rst,
    phy_rst_seq_if.slave  ctl
);

    // Reject parameter sets the counter cannot represent or that give a zero-length state.
    if (RST_CYC < 1) begin : g_bad_rst_cyc
        $error("phy_rst_seq: RST_CYC must be >= 1");
    end
    if (WAIT_CYC < 1) begin : g_bad_wait_cyc
        $error("phy_rst_seq: WAIT_CYC must be >= 1");
    end
    if (CNT_W < 1 || CNT_W > 31) begin : g_bad_cnt_w
        $error("phy_rst_seq: CNT_W must be in 1..31");
    end
    if (((RST_CYC - 1) >> CNT_W) != 0) begin : g_rst_cyc_fit
        $error("phy_rst_seq: RST_CYC-1 does not fit in CNT_W bits");
    end
    if (((WAIT_CYC - 1) >> CNT_W) != 0) begin : g_wait_cyc_fit
        $error("phy_rst_seq: WAIT_CYC-1 does not fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYC - 1);

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        WAIT = 2'd1,
        REL  = 2'd2,
        RUN  = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             phy_rstn_q;
    logic             mac_rstn_q;
    logic             ready_q;
    logic             ack_q;

    // Sequencer FSM; every output is a register so nothing leaks combinationally from inputs.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state      <= HOLD;
            cnt        <= '0;
            phy_rstn_q <= 1'b0;
            mac_rstn_q <= 1'b0;
            ready_q    <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state)
                HOLD: begin
                    if (cnt == RST_LAST) begin
                        cnt        <= '0;
                        phy_rstn_q <= 1'b1;
                        state      <= WAIT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (cnt == WAIT_LAST) begin
                        cnt        <= '0;
                        mac_rstn_q <= 1'b1;
                        state      <= REL;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                REL: begin
                    ready_q <= 1'b1;
                    state   <= RUN;
                end
                RUN: begin
                    cnt <= '0;
                    // A request is only honoured once the port is fully up.
                    if (ctl.soft_rst_req) begin
                        ack_q      <= 1'b1;
                        ready_q    <= 1'b0;
                        mac_rstn_q <= 1'b0;
                        phy_rstn_q <= 1'b0;
                        state      <= HOLD;
                    end
                end
                default: begin
                    state      <= HOLD;
                    cnt        <= '0;
                    phy_rstn_q <= 1'b0;
                    mac_rstn_q <= 1'b0;
                    ready_q    <= 1'b0;
                end
            endcase
        end
    end

    assign ctl.phy_rstn     = phy_rstn_q;
    assign ctl.mac_rstn     = mac_rstn_q;
    assign ctl.ready        = ready_q;
    assign ctl.soft_rst_ack = ack_q;

endmodule

// File: tb/tb_phy_rst_seq.sv
// Directed bench for phy_rst_seq: a default-parameter instance and a
// minimum-length (1/1) instance run side by side from a shared reset.
// Expected outputs come from an edge-count timing model queued per edge.
module tb_phy_rst_seq;

    localparam int R0 = 16;
    localparam int W0 = 32;
    localparam int R1 = 1;
    localparam int W1 = 1;

    logic sys_clk = 1'b0;
    logic rst     = 1'b1;

    phy_rst_seq_if bus0 ();
    phy_rst_seq_if bus1 ();

    phy_rst_seq #(.RST_CYC(R0), .WAIT_CYC(W0), .CNT_W(16)) dut0 (
        .sys_clk (sys_clk),
        .rst     (rst),
        .ctl     (bus0.slave)
    );

    phy_rst_seq #(.RST_CYC(R1), .WAIT_CYC(W1), .CNT_W(4)) dut1 (
        .sys_clk (sys_clk),
        .rst     (rst),
        .ctl     (bus1.slave)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int   edge_no;
        logic phy0, mac0, rdy0, ack0;
        logic phy1, mac1, rdy1, ack1;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Edge bookkeeping for the timing model: base is the edge a sequence restarted on.
    int   e     = 0;
    int   base0 = 0;
    int   base1 = 0;
    logic prev_ack0 = 1'b0;
    logic prev_ack1 = 1'b0;

    task automatic check(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // Build the expectation for the coming edge, clock it, then compare.
    task automatic tick();
        exp_t x;
        exp_t got;
        int   n0;
        int   n1;
        logic acc0;
        e = e + 1;
        acc0 = 1'b0;
        if (rst) begin
            base0 = e;
            base1 = e;
        end else if (bus0.soft_rst_req && ((e - 1 - base0) >= R0 + W0 + 1)) begin
            base0 = e;
            acc0  = 1'b1;
        end
        n0 = e - base0;
        n1 = e - base1;
        x.edge_no = e;
        x.phy0 = (n0 >= R0);
        x.mac0 = (n0 >= R0 + W0);
        x.rdy0 = (n0 >= R0 + W0 + 1);
        x.ack0 = acc0;
        x.phy1 = (n1 >= R1);
        x.mac1 = (n1 >= R1 + W1);
        x.rdy1 = (n1 >= R1 + W1 + 1);
        x.ack1 = 1'b0;
        exp_q.push_back(x);

        @(posedge sys_clk);
        #1;
        got = exp_q.pop_front();
        check($sformatf("e%0d dut0 phy_rstn", got.edge_no), bus0.phy_rstn, got.phy0);
        check($sformatf("e%0d dut0 mac_rstn", got.edge_no), bus0.mac_rstn, got.mac0);
        check($sformatf("e%0d dut0 ready", got.edge_no), bus0.ready, got.rdy0);
        check($sformatf("e%0d dut0 soft_rst_ack", got.edge_no), bus0.soft_rst_ack, got.ack0);
        check($sformatf("e%0d dut1 phy_rstn", got.edge_no), bus1.phy_rstn, got.phy1);
        check($sformatf("e%0d dut1 mac_rstn", got.edge_no), bus1.mac_rstn, got.mac1);
        check($sformatf("e%0d dut1 ready", got.edge_no), bus1.ready, got.rdy1);
        check($sformatf("e%0d dut1 soft_rst_ack", got.edge_no), bus1.soft_rst_ack, got.ack1);
        // Structural invariants on the observed outputs.
        check($sformatf("e%0d dut0 ready->mac", got.edge_no), !bus0.ready || bus0.mac_rstn, 1'b1);
        check($sformatf("e%0d dut0 mac->phy", got.edge_no), !bus0.mac_rstn || bus0.phy_rstn, 1'b1);
        check($sformatf("e%0d dut0 ack single", got.edge_no), prev_ack0 && bus0.soft_rst_ack, 1'b0);
        check($sformatf("e%0d dut1 ready->mac", got.edge_no), !bus1.ready || bus1.mac_rstn, 1'b1);
        check($sformatf("e%0d dut1 mac->phy", got.edge_no), !bus1.mac_rstn || bus1.phy_rstn, 1'b1);
        check($sformatf("e%0d dut1 ack single", got.edge_no), prev_ack1 && bus1.soft_rst_ack, 1'b0);
        prev_ack0 = bus0.soft_rst_ack;
        prev_ack1 = bus1.soft_rst_ack;
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) tick();
    endtask

    initial begin
        bus0.soft_rst_req = 1'b0;
        bus1.soft_rst_req = 1'b0;
        rst = 1'b1;
        #2;

        // Power-on reset for 5 cycles, then the full default sequence into RUN.
        run(5);
        rst = 1'b0;
        run(60);

        // One-cycle soft reset request while running, then let it come back up.
        bus0.soft_rst_req = 1'b1;
        tick();
        bus0.soft_rst_req = 1'b0;
        run(60);

        // Reset pulse while in RUN, then a request held high from edge 10.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run(9);
        bus0.soft_rst_req = 1'b1;
        run(112);
        bus0.soft_rst_req = 1'b0;
        run(55);

        // Reset pulse landing on edge 30 of a fresh sequence (inside WAIT).
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run(29);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run(60);

        // Request raised in the same cycle as a reset: reset wins, no ack.
        bus0.soft_rst_req = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus0.soft_rst_req = 1'b0;
        run(55);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/phy_rst_seq.md
PHY_RST_SEQ -- requirements
Module: phy_rst_seq

Interface
REQ-001 SHALL have parameter RST_CYC, default 16: cycles phy_rstn is held low per reset sequence.
REQ-002 SHALL have parameter WAIT_CYC, default 32: cycles between phy_rstn release and mac_rstn release.
REQ-003 SHALL have parameter CNT_W, default 16: width of the internal cycle counter.
REQ-004 sys_clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset, driven from the sys_clk domain (rstn_sys inverted).
REQ-006 soft_rst_req  input  1  level request from management to re-run the PHY/MAC reset sequence.
REQ-007 soft_rst_ack  output  1  one-cycle pulse acknowledging an accepted soft_rst_req.
REQ-008 phy_rstn  output  1  active-low hardware reset to the external PHY.
REQ-009 mac_rstn  output  1  active-low reset to the MAC datapath.
REQ-010 ready  output  1  high when the port is out of reset and running.

Function
REQ-011 All outputs SHALL be registered; none SHALL depend combinationally on any input.
REQ-012 FSM states SHALL be HOLD, WAIT, REL and RUN, with a CNT_W-bit counter cnt.
- HOLD: phy_rstn=0, mac_rstn=0; cnt increments; at cnt==RST_CYC-1: cnt<=0, phy_rstn<=1, go to WAIT.
- WAIT: phy_rstn=1, mac_rstn=0; cnt increments; at cnt==WAIT_CYC-1: cnt<=0, mac_rstn<=1, go to REL.
- REL: held for one cycle; ready<=1; go to RUN.
- RUN: all outputs released; cnt holds 0.
REQ-013 Timing: number the first rising edge with rst=0 as edge 1.
- phy_rstn SHALL go high after edge RST_CYC.
- mac_rstn SHALL go high after edge RST_CYC+WAIT_CYC.
- ready SHALL go high after edge RST_CYC+WAIT_CYC+1.
REQ-014 soft_rst_req SHALL be sampled only in RUN. If it is high at edge k in RUN, then after edge k:
- soft_rst_ack=1, ready=0, mac_rstn=0, phy_rstn=0, cnt=0, state HOLD.
- soft_rst_ack SHALL return to 0 after edge k+1.
REQ-015 After an accepted soft reset, the sequence SHALL repeat with the same timing: phy_rstn high after edge k+RST_CYC, mac_rstn high after edge k+RST_CYC+WAIT_CYC, ready high after edge k+RST_CYC+WAIT_CYC+1.
REQ-016 soft_rst_req high in HOLD, WAIT or REL SHALL be ignored and SHALL not be acknowledged; a request still high on entering RUN SHALL be accepted on the first RUN edge.
REQ-017 A requester holding soft_rst_req continuously SHALL cause back-to-back sequences, one ack per entry into RUN.
REQ-018 soft_rst_ack SHALL never be high for two consecutive cycles.
REQ-019 Invariants: ready=1 implies mac_rstn=1; mac_rstn=1 implies phy_rstn=1.
REQ-020 Parameter constraints:
- RST_CYC>=1 and WAIT_CYC>=1; at value 1 the state lasts exactly one cycle.
- RST_CYC-1 and WAIT_CYC-1 SHALL fit in CNT_W bits.
- Violations SHALL be flagged at elaboration.
REQ-021 The counter SHALL never wrap; terminal compares SHALL be equality on cnt.

Reset
REQ-022 While rst=1, at every edge: state=HOLD, cnt=0, phy_rstn=0, mac_rstn=0, ready=0, soft_rst_ack=0.
REQ-023 rst asserted mid-sequence or in RUN SHALL take effect at the next edge, aborting the sequence and any pending ack.
REQ-024 The sequence restarts from edge 1 per REQ-013 once rst falls.

Verification
REQ-025 Defaults; rst high 5 cycles then low -> phy_rstn rises after edge 16, mac_rstn after edge 48, ready after edge 49; soft_rst_ack stays 0.
REQ-026 In RUN, soft_rst_req high for 1 cycle at edge k -> ack pulse exactly 1 cycle, ready/mac_rstn/phy_rstn low after edge k, phy_rstn high after k+16, ready high after k+49.
REQ-027 soft_rst_req held high from edge 10 -> no ack before RUN; ack after edge 50; sequences repeat with one ack per 50 cycles.
REQ-028 rst pulsed for 1 cycle at edge 30 (in WAIT) -> phy_rstn low after edge 30; timing restarts per REQ-013 from the first edge with rst=0.
REQ-029 RST_CYC=1, WAIT_CYC=1 -> phy_rstn high after edge 1, mac_rstn after edge 2, ready after edge 3.
REQ-030 All scenarios: assert the REQ-019 invariants and REQ-018 every cycle.
